// File: rtl/banco_registros_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// address width helper and write-port identifiers used for priority.
package banco_registros_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 16;

  // Write-port identifiers. When both ports hit the same register in one
  // cycle, PORT_C (core/ALU) takes precedence over PORT_V (vector unit).
  typedef enum logic {
    PORT_C = 1'b0,
    PORT_V = 1'b1
  } wr_port_e;

  // Address width for a given depth. A depth of 1 still needs one bit so
  // that the address ports never collapse to zero width.
  function automatic int addr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/banco_registros_puerto_lectura.sv
// One registered read port with write-first bypass. The data captured on
// an enabled read is, in order of precedence: zero for unreadable
// addresses, the winning same-cycle write data, then the stored value.
module puerto_lectura
  import banco_registros_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_ok,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wr_c,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [WIDTH-1:0]  din_c,
  input  logic              wr_v,
  input  logic [ADDR_W-1:0] addr_v,
  input  logic [WIDTH-1:0]  din_v,
  output logic [WIDTH-1:0]  rd_data
);

  logic             hit_c;
  logic             hit_v;
  logic             fresh;
  wr_port_e         src;
  logic [WIDTH-1:0] byp_data;
  logic [WIDTH-1:0] next_data;

  // Select the value an enabled read captures this edge.
  always_comb begin
    hit_c     = wr_c && (addr_c == addr);
    hit_v     = wr_v && (addr_v == addr);
    fresh     = hit_c || hit_v;
    src       = hit_c ? PORT_C : PORT_V;
    byp_data  = (src == PORT_C) ? din_c : din_v;
    next_data = mem_data;
    if (!rd_ok) begin
      next_data = '0;
    end else if (fresh) begin
      next_data = byp_data;
    end
  end

  // Output register: cleared by reset, updated only on enabled reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= next_data;
    end
  end

endmodule

// File: rtl/banco_registros.sv
// Register file with two write ports (C over V on collisions), two
// registered read ports with write-first bypass, optional hardwired zero
// register and a registered same-address write conflict flag.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_c,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [WIDTH-1:0]  din_c,
  input  logic              we_v,
  input  logic [ADDR_W-1:0] addr_v,
  input  logic [WIDTH-1:0]  din_v,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [WIDTH-1:0]  do_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [WIDTH-1:0]  do_b,
  output logic              wr_conflict
);

  // Depth widened by one bit so the range check also works when DEPTH is
  // an exact power of two.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             same_addr;
  logic             wr_c;
  logic             wr_v;
  logic             ok_v;
  logic             conflict_next;
  logic             conflict_q;
  logic             rd_ok_a;
  logic             rd_ok_b;
  logic [WIDTH-1:0] mem_a;
  logic [WIDTH-1:0] mem_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Write arbitration, conflict detection and storage read muxes.
  always_comb begin
    same_addr     = (addr_c == addr_v);
    wr_c          = we_c && in_range(addr_c) && !is_zero_reg(addr_c);
    ok_v          = we_v && in_range(addr_v) && !is_zero_reg(addr_v);
    // V is dropped whenever C writes the same register.
    wr_v          = ok_v && !(wr_c && same_addr);
    // A collision on register 0 still counts when it is hardwired; only
    // out-of-range collisions are silent.
    conflict_next = we_c && we_v && same_addr && in_range(addr_c);
    rd_ok_a       = in_range(addr_a) && !is_zero_reg(addr_a);
    rd_ok_b       = in_range(addr_b) && !is_zero_reg(addr_b);
    mem_a         = '0;
    mem_b         = '0;
    if (in_range(addr_a)) begin
      mem_a = mem[addr_a];
    end
    if (in_range(addr_b)) begin
      mem_b = mem[addr_b];
    end
  end

  // Storage array: cleared by reset, then written by the arbitrated ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_c) begin
        mem[addr_c] <= din_c;
      end
      if (wr_v) begin
        mem[addr_v] <= din_v;
      end
    end
  end

  // Conflict flag: high exactly in the cycle after a same-address write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_next;
    end
  end

  assign wr_conflict = conflict_q;

  puerto_lectura #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_lectura_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .re       (re_a),
    .addr     (addr_a),
    .rd_ok    (rd_ok_a),
    .mem_data (mem_a),
    .wr_c     (wr_c),
    .addr_c   (addr_c),
    .din_c    (din_c),
    .wr_v     (wr_v),
    .addr_v   (addr_v),
    .din_v    (din_v),
    .rd_data  (do_a)
  );

  puerto_lectura #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_lectura_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .re       (re_b),
    .addr     (addr_b),
    .rd_ok    (rd_ok_b),
    .mem_data (mem_b),
    .wr_c     (wr_c),
    .addr_c   (addr_c),
    .din_c    (din_c),
    .wr_v     (wr_v),
    .addr_v   (addr_v),
    .din_v    (din_v),
    .rd_data  (do_b)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: two instances on shared inputs, one with
// DEPTH=12/ZERO_REG=1 and one with DEPTH=16/ZERO_REG=0. A directed table
// with hand-derived results for the first instance, a behavioural model
// feeding a scoreboard queue for both, then randomised traffic.
module tb_banco_registros;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        we_c, we_v, re_a, re_b;
  logic [3:0]  addr_c, addr_v, addr_a, addr_b;
  logic [31:0] din_c, din_v;
  logic [31:0] do_a0, do_b0, do_a1, do_b1;
  logic        cf0, cf1;

  int checks = 0;
  int errors = 0;

  banco_registros #(.WIDTH(32), .DEPTH(12), .ZERO_REG(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .we_c(we_c), .addr_c(addr_c), .din_c(din_c),
    .we_v(we_v), .addr_v(addr_v), .din_v(din_v),
    .re_a(re_a), .addr_a(addr_a), .do_a(do_a0),
    .re_b(re_b), .addr_b(addr_b), .do_b(do_b0),
    .wr_conflict(cf0)
  );

  banco_registros #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .we_c(we_c), .addr_c(addr_c), .din_c(din_c),
    .we_v(we_v), .addr_v(addr_v), .din_v(din_v),
    .re_a(re_a), .addr_a(addr_a), .do_a(do_a1),
    .re_b(re_b), .addr_b(addr_b), .do_b(do_b1),
    .wr_conflict(cf1)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        rst_n;
    logic        we_c;
    logic [3:0]  addr_c;
    logic [31:0] din_c;
    logic        we_v;
    logic [3:0]  addr_v;
    logic [31:0] din_v;
    logic        re_a;
    logic [3:0]  addr_a;
    logic        re_b;
    logic [3:0]  addr_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_cf;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cf;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [31:0] mdl [2][16];
  logic [31:0] last_a [2];
  logic [31:0] last_b [2];

  localparam int N_TAB = 27;
  vec_t tab [N_TAB];

  function automatic vec_t mk(input logic rs, input logic wc, input logic [3:0] ac,
                              input logic [31:0] dc, input logic wv, input logic [3:0] av,
                              input logic [31:0] dv, input logic ra, input logic [3:0] aa,
                              input logic rb, input logic [3:0] ab, input logic [31:0] ea,
                              input logic [31:0] eb, input logic ecf);
    vec_t v;
    v.rst_n = rs; v.we_c = wc; v.addr_c = ac; v.din_c = dc;
    v.we_v = wv; v.addr_v = av; v.din_v = dv;
    v.re_a = ra; v.addr_a = aa; v.re_b = rb; v.addr_b = ab;
    v.exp_a = ea; v.exp_b = eb; v.exp_cf = ecf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour of instance i for the inputs currently driven.
  function automatic logic readable(input int i, input logic [3:0] a);
    int d;
    d = (i == 0) ? 12 : 16;
    return (int'(a) < d) && !((i == 0) && (a == 4'd0));
  endfunction

  task automatic model_step(input int i, output exp_t e);
    logic okc, okv;
    logic [31:0] ra, rb;
    int d;
    d = (i == 0) ? 12 : 16;
    if (!rst_n) begin
      for (int j = 0; j < 16; j++) mdl[i][j] = 32'h0;
      last_a[i] = 32'h0;
      last_b[i] = 32'h0;
      e.a = 32'h0; e.b = 32'h0; e.cf = 1'b0;
    end else begin
      okc = we_c && readable(i, addr_c);
      okv = we_v && readable(i, addr_v);
      e.cf = we_c && we_v && (addr_c == addr_v) && (int'(addr_c) < d);
      ra = 32'h0;
      if (readable(i, addr_a)) begin
        if (okc && addr_c == addr_a) ra = din_c;
        else if (okv && addr_v == addr_a) ra = din_v;
        else ra = mdl[i][addr_a];
      end
      rb = 32'h0;
      if (readable(i, addr_b)) begin
        if (okc && addr_c == addr_b) rb = din_c;
        else if (okv && addr_v == addr_b) rb = din_v;
        else rb = mdl[i][addr_b];
      end
      if (re_a) last_a[i] = ra;
      if (re_b) last_b[i] = rb;
      e.a = last_a[i];
      e.b = last_b[i];
      // V first, then C, so C overwrites on a shared address.
      if (okv) mdl[i][addr_v] = din_v;
      if (okc) mdl[i][addr_c] = din_c;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rst_n  = v.rst_n;
    we_c   = v.we_c;  addr_c = v.addr_c; din_c = v.din_c;
    we_v   = v.we_v;  addr_v = v.addr_v; din_v = v.din_v;
    re_a   = v.re_a;  addr_a = v.addr_a;
    re_b   = v.re_b;  addr_b = v.addr_b;
  endtask

  task automatic run_cycle(input string tag, input bit use_tab, input vec_t v);
    exp_t e0, e1, g0, g1;
    @(negedge clk);
    drive(v);
    model_step(0, e0);
    model_step(1, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    @(posedge clk);
    #1;
    g0 = exp_q0.pop_front();
    g1 = exp_q1.pop_front();
    check({tag, " u0 do_a"}, do_a0, g0.a);
    check({tag, " u0 do_b"}, do_b0, g0.b);
    check({tag, " u0 conflict"}, {31'h0, cf0}, {31'h0, g0.cf});
    check({tag, " u1 do_a"}, do_a1, g1.a);
    check({tag, " u1 do_b"}, do_b1, g1.b);
    check({tag, " u1 conflict"}, {31'h0, cf1}, {31'h0, g1.cf});
    if (use_tab) begin
      check({tag, " tab do_a"}, do_a0, v.exp_a);
      check({tag, " tab do_b"}, do_b0, v.exp_b);
      check({tag, " tab conflict"}, {31'h0, cf0}, {31'h0, v.exp_cf});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Expected columns are for u_dut0 (DEPTH=12, ZERO_REG=1).
    //         rst wc ac dc              wv av dv              ra aa rb ab  exp_a          exp_b          cf
    tab[0]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  32'h0,         32'h0,         0);
    tab[1]  = mk(1, 1, 3, 32'hDEADBEEF,  0, 0, 32'h0,         0, 0, 0, 0,  32'h0,         32'h0,         0);
    tab[2]  = mk(0, 1, 3, 32'h12345678,  0, 0, 32'h0,         1, 3, 0, 0,  32'h0,         32'h0,         0);
    tab[3]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 0, 0,  32'h0,         32'h0,         0);
    tab[4]  = mk(1, 1, 2, 32'h11111111,  1, 5, 32'h22222222,  0, 0, 0, 0,  32'h0,         32'h0,         0);
    tab[5]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 1, 5,  32'h11111111,  32'h22222222,  0);
    tab[6]  = mk(1, 1, 7, 32'hAAAA0000,  1, 7, 32'h0000BBBB,  0, 0, 0, 0,  32'h11111111,  32'h22222222,  1);
    tab[7]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 7, 0, 0,  32'hAAAA0000,  32'h22222222,  0);
    tab[8]  = mk(1, 1, 4, 32'h1,         0, 0, 32'h0,         0, 0, 0, 0,  32'hAAAA0000,  32'h22222222,  0);
    tab[9]  = mk(1, 0, 0, 32'h0,         1, 4, 32'h5,         1, 4, 0, 0,  32'h5,         32'h22222222,  0);
    tab[10] = mk(1, 1, 6, 32'h66,        1, 6, 32'h77,        1, 6, 1, 6,  32'h66,        32'h66,        1);
    tab[11] = mk(1, 1, 8, 32'h88,        1, 8, 32'h99,        0, 0, 0, 0,  32'h66,        32'h66,        1);
    tab[12] = mk(1, 1, 9, 32'h9C,        1, 9, 32'h9F,        0, 0, 1, 8,  32'h66,        32'h88,        1);
    tab[13] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  32'h66,        32'h88,        0);
    tab[14] = mk(1, 1, 0, 32'hFFFFFFFF,  0, 0, 32'h0,         1, 0, 0, 0,  32'h0,         32'h88,        0);
    tab[15] = mk(1, 1, 0, 32'h1,         1, 0, 32'hFFFFFFFF,  0, 0, 1, 0,  32'h0,         32'h0,         1);
    tab[16] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 0,  32'h0,         32'h0,         0);
    tab[17] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 2, 0, 0,  32'h0,         32'h0,         0);
    tab[18] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 3, 0, 0,  32'h0,         32'h0,         0);
    tab[19] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 5, 0, 0,  32'h0,         32'h0,         0);
    tab[20] = mk(1, 1, 13, 32'h13131313, 1, 13, 32'h13131313, 0, 0, 1, 13, 32'h0,         32'h0,         0);
    tab[21] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 11, 1, 13, 32'h0,        32'h0,         0);
    tab[22] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 15, 1, 12, 32'h0,        32'h0,         0);
    tab[23] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 1, 5,  32'h11111111,  32'h22222222,  0);
    tab[24] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 1, 9,  32'h0,         32'h9C,        0);
    tab[25] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 0, 0,  32'h0,         32'h0,         0);
    tab[26] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 0, 0,  32'h0,         32'h0,         0);

    for (int r = 0; r < N_TAB; r++) begin
      run_cycle($sformatf("row%0d", r), 1'b1, tab[r]);
    end

    // Sweep every address of both instances to confirm nothing stray was
    // written by the out-of-range and zero-register cases.
    for (int a = 0; a < 16; a += 2) begin
      v = mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 4'(a), 1, 4'(a + 1), 32'h0, 32'h0, 0);
      run_cycle($sformatf("sweep%0d", a), 1'b0, v);
    end

    // Randomised traffic with frequent address collisions and rare resets.
    for (int n = 0; n < 400; n++) begin
      v.rst_n  = ($urandom_range(0, 49) != 0);
      v.we_c   = 1'($urandom_range(0, 1));
      v.addr_c = 4'($urandom_range(0, 15));
      v.din_c  = $urandom;
      v.we_v   = 1'($urandom_range(0, 1));
      v.addr_v = ($urandom_range(0, 3) == 0) ? v.addr_c : 4'($urandom_range(0, 15));
      v.din_v  = $urandom;
      v.re_a   = 1'($urandom_range(0, 1));
      v.addr_a = ($urandom_range(0, 3) == 0) ? v.addr_c : 4'($urandom_range(0, 15));
      v.re_b   = 1'($urandom_range(0, 1));
      v.addr_b = ($urandom_range(0, 3) == 0) ? v.addr_v : 4'($urandom_range(0, 15));
      v.exp_a  = 32'h0;
      v.exp_b  = 32'h0;
      v.exp_cf = 1'b0;
      run_cycle($sformatf("rand%0d", n), 1'b0, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
